// File: rtl/booth_step_sequencer.sv
// Radix-2 Booth sequencer: loads signed operands, feeds the one-bit selector,
// strobes its enable and accumulates the selected addend into a signed product.
// Ports: clk, rst (async high), start, x_in, y_in, one_bit_mult_x (selector
//   addend) in; xreg, negate_xreg, yreg, en_mult_one_bit_y, product, busy, done out.
module booth_step_sequencer #(
  parameter int N_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BITS-1:0]     x_in,
  input  logic [N_BITS-1:0]     y_in,
  input  logic [2*N_BITS-1:0]   one_bit_mult_x,
  output logic [2*N_BITS-1:0]   xreg,
  output logic [2*N_BITS-1:0]   negate_xreg,
  output logic [N_BITS:0]       yreg,
  output logic                  en_mult_one_bit_y,
  output logic [2*N_BITS-1:0]   product,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = 2 * N_BITS;
  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    STROBE,
    ADD,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] acc;
  logic [PW-1:0] sum;
  logic [CW-1:0] cnt;

  assign negate_xreg = {PW{1'b0}} - xreg;
  assign sum         = acc + one_bit_mult_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      xreg              <= '0;
      yreg              <= '0;
      acc               <= '0;
      cnt               <= '0;
      product           <= '0;
      en_mult_one_bit_y <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xreg  <= {{N_BITS{x_in[N_BITS-1]}}, x_in};
            yreg  <= {y_in, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SEL;
          end
        end
        SEL: begin
          // en rises a full cycle after operands settle
          en_mult_one_bit_y <= 1'b1;
          state             <= STROBE;
        end
        STROBE: begin
          en_mult_one_bit_y <= 1'b0;
          state             <= ADD;
        end
        ADD: begin
          acc  <= sum;
          xreg <= {xreg[PW-2:0], 1'b0};
          yreg <= {yreg[N_BITS], yreg[N_BITS:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= sum;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= SEL;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en_mult_one_bit_y <= 1'b0;
          busy              <= 1'b0;
          done              <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/booth_step_sequencer.md
Name: booth_step_sequencer

Overview:
- Controller/datapath that drives the radix-2 Booth one-bit selector stage and consumes its output.
- Loads a 6-bit signed multiplicand and multiplier, then presents the shifted multiplicand, its negation and the Booth window of the multiplier to the selector.
- Strobes the selector's enable and accumulates the selected addend over 6 iterations.
- Returns a 12-bit signed product with a one-cycle done pulse.

Parameters:
- N_BITS, 6, operand width; iteration count; product width is 2*N_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- x_in  input  6  signed multiplicand.
- y_in  input  6  signed multiplier.
- one_bit_mult_x  input  12  addend returned by the selector (0, xreg or negate_xreg).
- xreg  output  12  shifted, sign-extended multiplicand presented to the selector.
- negate_xreg  output  12  two's complement of xreg; combinational, modulo 2^12.
- yreg  output  7  multiplier window {y, prev bit}; the selector uses yreg[1:0].
- en_mult_one_bit_y  output  1  registered strobe; its rising edge makes the selector latch.
- product  output  12  signed result; held until the next load.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when product becomes valid.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; xreg, yreg, acc, product and cnt = 0.
  - en_mult_one_bit_y=0, done=0, busy=0.
  - en must fall immediately and never glitch high during or after reset.
- FSM states: IDLE, SEL, STROBE, ADD, DONE. All outputs except negate_xreg are registered.
- IDLE:
  - On a clk edge with start=1: xreg<=sign-extend(x_in) to 12 bits; yreg<={y_in,1'b0}; acc<=0; cnt<=0; go to SEL.
  - start=0: stay in IDLE.
- SEL: operands are stable for this cycle with en=0. Next edge goes to STROBE.
- STROBE: en_mult_one_bit_y=1 for exactly this cycle. The rising edge of en occurs one full cycle after the operands changed, so there is no race with the selector. Next edge goes to ADD.
- ADD: on the exiting edge:
  - acc<=acc+one_bit_mult_x, 12-bit wrap.
  - xreg<=xreg<<1, zero fill.
  - yreg<=arithmetic right shift of yreg by 1.
  - cnt<=cnt+1.
  - If cnt==N_BITS-1, go to DONE and latch product<=acc+one_bit_mult_x; else go to SEL.
- DONE: done=1 for one cycle; next edge goes to IDLE.
- Per-bit cost is 3 cycles.
  - With start sampled at edge E0, additions occur at edges E3, E6, …, E18.
  - done is high in the cycle after E18; busy falls at E19.
- start while busy is ignored; operands are not reloaded. start during DONE is also ignored. start is accepted again from IDLE, one cycle after done.
- x_in and y_in are sampled only on the load edge. Later changes have no effect.
- Range: the full 6-bit signed range gives a product within ±1024, so there is no overflow in 12 bits.
- Reset mid-operation aborts the multiply. product clears to 0 and no done pulse is generated.

Test Plan:
- Behavioural selector model on the bench; 5 × 3 -> done 18 cycles after start edge; product=12'h00F; exactly 6 rising edges of en.
- -7 × 5 -> product=12'hFDD (-35); -32 × -32 -> 12'h400 (1024); 31 × -32 -> 12'hC20 (-992).
- 0 × -1 and -1 × 0 -> product=0. Check negate_xreg==(~xreg+1) at every en rising edge, and that yreg[1:0] is stable for the whole STROBE cycle.
- start pulsed again at cycle 5 of a 5×3 run with x_in=9 -> ignored; result still 12'h00F. start the cycle after done -> new multiply accepted.
- rst asserted asynchronously mid-STROBE of iteration 3 -> en, busy and product immediately 0; no done. A following 2 × 2 gives 12'h004.
- Back-to-back random signed pairs (≥200) -> every product matches the reference multiply; done is always a single-cycle pulse.
